// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S multicycle processor: instruction
// decode enumeration, opcode bytes and ALU operation codes.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BSOV, I_HALT
    } decoded_instruction_type;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNEG   = 8'h03;
    localparam logic [7:0] OP_BOV    = 8'h04;
    localparam logic [7:0] OP_BSOV   = 8'h05;
    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Unlisted opcode bytes fall back to NOP so stray data never acts as an instruction.
    function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
        decoded_instruction_type d;
        d = I_NOP;
        case (opc)
            OP_BRANCH: d = I_BRANCH;
            OP_BZERO:  d = I_BZERO;
            OP_BNEG:   d = I_BNEG;
            OP_BOV:    d = I_BOV;
            OP_BSOV:   d = I_BSOV;
            OP_LOAD:   d = I_LOAD;
            OP_STORE:  d = I_STORE;
            OP_MOVE:   d = I_MOVE;
            OP_ADD:    d = I_ADD;
            OP_SUB:    d = I_SUB;
            OP_AND:    d = I_AND;
            OP_OR:     d = I_OR;
            OP_HALT:   d = I_HALT;
            default:   d = I_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ks_alu.sv
// Combinational ALU: ADD/SUB/AND/OR with zero, negative, carry/borrow and
// signed-overflow flags.
module ks_alu
    import k_and_s_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   operation,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         neg,
    output logic         unsigned_overflow,
    output logic         signed_overflow
);

    logic [W:0] sum;
    logic [W:0] diff;

    // The extra top bit is the carry for ADD and the borrow for SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result            = '0;
        unsigned_overflow = 1'b0;
        signed_overflow   = 1'b0;
        case (operation)
            ALU_ADD: begin
                result            = sum[W-1:0];
                unsigned_overflow = sum[W];
                signed_overflow   = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result            = diff[W-1:0];
                unsigned_overflow = diff[W];
                signed_overflow   = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_AND: result = a & b;
            default: result = a | b;
        endcase
        zero = (result == '0);
        neg  = result[W-1];
    end

endmodule

// File: rtl/data_path.sv
// K&S multicycle datapath: PC, IR, 4-entry register file, ALU and flag
// register, sequenced cycle by cycle by the control unit.
module data_path
    import k_and_s_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_PC   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out
);

    logic [DATA_WIDTH-1:0]      ir;
    logic [ADDR_WIDTH-1:0]      pc;
    logic [3:0][DATA_WIDTH-1:0] regs;
    logic [1:0]                 a_idx, b_idx, rd_idx;
    logic [DATA_WIDTH-1:0]      bus_a, bus_b, alu_out;
    logic                       alu_zero, alu_neg, alu_uov, alu_sov;
    logic                       unused_ir;

    assign decoded_instruction = decode_opcode(ir[DATA_WIDTH-1 -: 8]);
    assign unused_ir           = ^ir[DATA_WIDTH-9:7];

    // Operand/destination fields move around the IR depending on the format.
    always_comb begin
        a_idx  = ir[3:2];
        b_idx  = ir[1:0];
        rd_idx = ir[5:4];
        case (decoded_instruction)
            I_MOVE: begin
                a_idx  = ir[1:0];
                rd_idx = ir[3:2];
            end
            I_STORE: a_idx  = ir[6:5];
            I_LOAD:  rd_idx = ir[6:5];
            default: ;
        endcase
    end

    assign bus_a    = regs[a_idx];
    assign bus_b    = regs[b_idx];
    assign data_out = bus_a;
    assign ram_addr = addr_sel ? ir[ADDR_WIDTH-1:0] : pc;

    ks_alu #(.W(DATA_WIDTH)) u_alu (
        .a                 (bus_a),
        .b                 (bus_b),
        .operation         (operation),
        .result            (alu_out),
        .zero              (alu_zero),
        .neg               (alu_neg),
        .unsigned_overflow (alu_uov),
        .signed_overflow   (alu_sov)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= ADDR_WIDTH'(RESET_PC);
        else if (pc_enable)
            pc <= branch ? ir[ADDR_WIDTH-1:0] : pc + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ir <= '0;
        else if (ir_enable)
            ir <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (write_reg_enable)
            regs[rd_idx] <= c_sel ? data_in : alu_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= alu_zero;
            neg_op            <= alu_neg;
            unsigned_overflow <= alu_uov;
            signed_overflow   <= alu_sov;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: drives control strobes cycle by cycle
// against a small RAM model and checks registers via STORE readback.
module tb_data_path;
    import k_and_s_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    branch = 1'b0, pc_enable = 1'b0, ir_enable = 1'b0;
    logic                    write_reg_enable = 1'b0, addr_sel = 1'b0, c_sel = 1'b0;
    logic [1:0]              operation = 2'b00;
    logic                    flags_reg_enable = 1'b0;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]              ram_addr;
    logic [15:0]             data_in, data_out;

    logic [15:0] ram [32];
    assign data_in = ram[ram_addr];

    always #5 clk = ~clk;

    data_path #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .write_reg_enable(write_reg_enable),
        .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
        .flags_reg_enable(flags_reg_enable), .decoded_instruction(decoded_instruction),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
        .signed_overflow(signed_overflow), .ram_addr(ram_addr),
        .data_in(data_in), .data_out(data_out)
    );

    typedef struct { string tag; logic [31:0] exp; } sb_t;
    sb_t         sb_q[$];
    int          n_chk = 0, n_fail = 0;
    logic [4:0]  pc_m = 5'd0;
    logic [15:0] regs_m [4];
    logic [3:0]  flags_m = 4'd0;   // {zero, neg, unsigned_ovf, signed_ovf}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [31:0] flags_obs();
        return 32'({zero_op, neg_op, unsigned_overflow, signed_overflow});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        c_sel = 0; flags_reg_enable = 0;
    endtask

    task automatic fetch(input logic [15:0] word, input logic inc);
        addr_sel = 0;
        ram[pc_m] = word;
        ir_enable = 1;
        pc_enable = inc;
        tick();
        if (inc) pc_m = pc_m + 5'd1;
    endtask

    task automatic set_reg(input logic [1:0] r, input logic [15:0] val);
        fetch({8'h81, 1'b0, r, 5'd10}, 1'b0);
        ram[10] = val;
        addr_sel = 1; c_sel = 1; write_reg_enable = 1;
        tick();
        regs_m[r] = val;
        addr_sel = 0;
    endtask

    task automatic read_reg(input logic [1:0] r, input string tag, input logic [15:0] exp);
        fetch({8'h82, 1'b0, r, 5'd11}, 1'b0);
        sb_push(tag, 32'(exp));
        sb_check(32'(data_out));
    endtask

    function automatic logic [19:0] alu_model(input logic [15:0] a, b, input logic [1:0] op);
        logic [15:0] r;
        logic        uo, so;
        uo = 0; so = 0;
        case (op)
            ALU_ADD: begin
                r  = a + b;
                uo = (17'(a) + 17'(b)) > 17'h0FFFF;
                so = (a[15] == b[15]) && (r[15] != a[15]);
            end
            ALU_SUB: begin
                r  = a - b;
                uo = a < b;
                so = (a[15] != b[15]) && (r[15] != a[15]);
            end
            ALU_AND: r = a & b;
            default: r = a | b;
        endcase
        return {r == 16'd0, r[15], uo, so, r};
    endfunction

    task automatic alu_op(input logic [7:0] opc, input logic [1:0] rd, ra, rb, op,
                          input logic fl_en);
        logic [19:0] m;
        fetch({opc, 2'b00, rd, ra, rb}, 1'b0);
        m = alu_model(regs_m[ra], regs_m[rb], op);
        operation = op; c_sel = 0; write_reg_enable = 1; flags_reg_enable = fl_en;
        tick();
        regs_m[rd] = m[15:0];
        if (fl_en) flags_m = m[19:16];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 16'h0000;
        for (int i = 0; i < 4; i++) regs_m[i] = 16'h0000;
        ram[0] = 16'h8125;

        // Reset state
        #1;
        chk("rst_pc", 32'(ram_addr), 32'd0);
        chk("rst_dec", 32'(decoded_instruction), 32'(I_NOP));
        chk("rst_flags", flags_obs(), 32'd0);
        #11 rst_n = 1;

        // Fetch with simultaneous PC increment
        fetch(16'h8125, 1'b1);
        chk("fetch_dec", 32'(decoded_instruction), 32'(I_LOAD));
        chk("fetch_pc", 32'(ram_addr), 32'd1);
        addr_sel = 1; #1;
        chk("load_addr", 32'(ram_addr), 32'd5);

        // LOAD R1 <- RAM[5]
        ram[5] = 16'h1234;
        c_sel = 1; write_reg_enable = 1;
        tick();
        regs_m[1] = 16'h1234;
        read_reg(2'd1, "load_r1", 16'h1234);
        read_reg(2'd0, "load_r0", 16'h0000);
        read_reg(2'd2, "load_r2", 16'h0000);
        read_reg(2'd3, "load_r3", 16'h0000);

        // ADD 7FFF + 0001: signed overflow into negative
        set_reg(2'd1, 16'h7FFF);
        set_reg(2'd2, 16'h0001);
        alu_op(8'hA1, 2'd0, 2'd1, 2'd2, ALU_ADD, 1'b1);
        chk("add_flags", flags_obs(), 32'b0101);
        read_reg(2'd0, "add_r0", 16'h8000);

        // SUB 3 - 5: borrow, negative; then equal operands give zero
        set_reg(2'd1, 16'h0003);
        set_reg(2'd2, 16'h0005);
        alu_op(8'hA2, 2'd0, 2'd1, 2'd2, ALU_SUB, 1'b1);
        chk("sub_flags", flags_obs(), 32'b0110);
        read_reg(2'd0, "sub_r0", 16'hFFFE);
        set_reg(2'd2, 16'h0003);
        alu_op(8'hA2, 2'd0, 2'd1, 2'd2, ALU_SUB, 1'b1);
        chk("sub_zero", flags_obs(), 32'b1000);

        // Signed overflow on SUB: 8000 - 0001
        set_reg(2'd1, 16'h8000);
        set_reg(2'd2, 16'h0001);
        alu_op(8'hA2, 2'd3, 2'd1, 2'd2, ALU_SUB, 1'b1);
        chk("subov_flags", flags_obs(), 32'(flags_m));
        chk("subov_const", flags_obs(), 32'b0001);
        read_reg(2'd3, "subov_r3", regs_m[3]);

        // AND / OR clear overflow flags
        set_reg(2'd1, 16'hF0F0);
        set_reg(2'd2, 16'h8F0F);
        alu_op(8'hA3, 2'd3, 2'd1, 2'd2, ALU_AND, 1'b1);
        chk("and_flags", flags_obs(), 32'(flags_m));
        read_reg(2'd3, "and_r3", 16'h8000);
        alu_op(8'hA4, 2'd0, 2'd1, 2'd2, ALU_OR, 1'b1);
        read_reg(2'd0, "or_r0", 16'hFFFF);

        // Flags hold when not enabled
        alu_op(8'hA2, 2'd0, 2'd1, 2'd1, ALU_SUB, 1'b0);
        chk("flags_hold", flags_obs(), 32'b0100);
        read_reg(2'd0, "nofl_r0", 16'h0000);

        // MOVE R1 <- R3 (rd=[3:2], rs=[1:0])
        alu_op(8'h91, 2'd0, 2'd1, 2'd3, ALU_OR, 1'b0);
        chk("move_dec", 32'(decoded_instruction), 32'(I_MOVE));
        regs_m[1] = regs_m[3];
        read_reg(2'd1, "move_r1", 16'h8000);

        // Decode corners
        fetch(16'hFF00, 1'b0);
        chk("dec_halt", 32'(decoded_instruction), 32'(I_HALT));
        fetch(16'h7700, 1'b0);
        chk("dec_unk", 32'(decoded_instruction), 32'(I_NOP));
        fetch(16'h0500, 1'b0);
        chk("dec_bsov", 32'(decoded_instruction), 32'(I_BSOV));

        // Branch and PC wrap
        fetch(16'h0113, 1'b0);
        chk("dec_branch", 32'(decoded_instruction), 32'(I_BRANCH));
        branch = 1; pc_enable = 1;
        tick();
        pc_m = 5'h13;
        chk("br_pc", 32'(ram_addr), 32'h13);
        fetch(16'h011F, 1'b0);
        branch = 1; pc_enable = 1;
        tick();
        pc_m = 5'h1F;
        chk("br_pc31", 32'(ram_addr), 32'h1F);
        pc_enable = 1;
        tick();
        pc_m = 5'h00;
        chk("pc_wrap", 32'(ram_addr), 32'h00);

        // STORE R2 to address 3
        set_reg(2'd0, 16'h5A5A);
        set_reg(2'd2, 16'hABCD);
        alu_op(8'hA1, 2'd3, 2'd2, 2'd2, ALU_ADD, 1'b1);
        fetch(16'h8243, 1'b1);
        chk("st_dec", 32'(decoded_instruction), 32'(I_STORE));
        chk("st_data", 32'(data_out), 32'hABCD);
        addr_sel = 1; #1;
        chk("st_addr", 32'(ram_addr), 32'd3);
        chk("pre_rst_flags", flags_obs(), 32'(flags_m));

        // Asynchronous reset mid-cycle, no clock edge involved
        addr_sel = 0;
        #1 rst_n = 0;
        #1;
        chk("arst_pc", 32'(ram_addr), 32'd0);
        chk("arst_dec", 32'(decoded_instruction), 32'(I_NOP));
        chk("arst_flags", flags_obs(), 32'd0);
        chk("arst_r0", 32'(data_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        pc_m = 5'd0;
        for (int i = 0; i < 4; i++) regs_m[i] = 16'h0000;
        read_reg(2'd2, "arst_r2", regs_m[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Datapath of the K&S multicycle processor, driven cycle by cycle by the control unit.
- Holds the PC, IR, a 4x16 register file, the ALU and the flag register.
- Decodes the IR into decoded_instruction and returns the registered flags to the control unit.
- Generates the RAM address and RAM write data; reads RAM data for instruction fetch and LOAD.

Parameters:
- DATA_WIDTH, 16, word width of registers, ALU, IR and RAM data.
- ADDR_WIDTH, 5, RAM word address width (32 words).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- branch  in  1  PC load source select: 1 = IR[4:0], 0 = PC+1
- pc_enable  in  1  PC update strobe
- ir_enable  in  1  IR load from data_in
- write_reg_enable  in  1  register-file write strobe
- addr_sel  in  1  ram_addr source select: 1 = IR[4:0], 0 = PC
- c_sel  in  1  register write-data select: 1 = data_in, 0 = ALU result
- operation  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
- flags_reg_enable  in  1  flag-register load strobe
- decoded_instruction  out  decoded_instruction_type  decode of current IR
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags
- ram_addr  out  ADDR_WIDTH  RAM address
- data_in  in  DATA_WIDTH  RAM read data (combinational RAM read)
- data_out  out  DATA_WIDTH  RAM write data

Behaviour:
- Encoding, upper byte IR[15:8]:
  - 00 NOP; 01 BRANCH; 02 BZERO; 03 BNEG; 04 BOV (unsigned); 05 BSOV (signed).
  - 81 LOAD, with rd=[6:5], addr=[4:0]; 82 STORE, with rs=[6:5], addr=[4:0].
  - 91 MOVE, with rd=[3:2], rs=[1:0].
  - A1 ADD, A2 SUB, A3 AND, A4 OR, each with rd=[5:4], ra=[3:2], rb=[1:0].
  - FF HALT. Any other value decodes to I_NOP.
- Reset: PC=RESET_PC; IR=0 (decodes to I_NOP); all registers 0; all flags 0.
  - Asynchronous: takes effect mid-instruction with no partial writes completing.
- PC:
  - On a clk edge with pc_enable: branch=1 gives PC<=IR[4:0]; branch=0 gives PC<=PC+1.
  - PC+1 wraps from 31 to 0. No change without pc_enable.
- IR: on ir_enable, IR<=data_in. Simultaneous ir_enable and pc_enable is legal and common; PC increments independently of the new IR.
- ram_addr = addr_sel ? IR[4:0] : PC. Combinational.
- Operand buses:
  - bus_a index: MOVE uses [1:0]; STORE uses [6:5]; otherwise [3:2].
  - bus_b index: MOVE uses [1:0]; otherwise [1:0].
  - MOVE is executed as OR of a register with itself.
- data_out = bus_a. ram_write_enable (driven by the control unit) qualifies it.
- Register write:
  - On write_reg_enable: R[rd] <= c_sel ? data_in : alu_out.
  - rd is [6:5] for LOAD, [3:2] for MOVE, [5:4] for ALU ops.
  - Write-before-read is not required. Reads are combinational from current register state.
- ALU, DATA_WIDTH bits, wrap-around arithmetic:
  - ADD: unsigned_overflow = carry out; signed_overflow = operands share a sign and result sign differs.
  - SUB is a-b: unsigned_overflow = borrow (a<b unsigned); signed_overflow = operand signs differ and result sign differs from a.
  - AND/OR: both overflow flags 0.
  - zero = (result==0); neg = result[MSB].
- Flags: the four flags load together on flags_reg_enable; they hold otherwise.
- Decode: purely combinational from IR. No decode latency beyond the IR register.
- Latencies:
  - Fetch: IR valid one clk after ir_enable.
  - LOAD data is written on the edge where write_reg_enable=1.

Decomposition:
- k_and_s_pkg holds:
  - decoded_instruction_type: I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BSOV, I_HALT.
  - Opcode byte constants.
  - ALU operation constants (ALU_ADD/SUB/AND/OR).
- One sub-module: ks_alu. It is combinational, with inputs a, b, operation and outputs result plus the four raw flags.
- The register file, PC, IR and flag register are kept inline.

Test Plan:
- Reset with RAM[0]=16'h8125 -> PC=0, decoded_instruction=I_NOP, flags 0. Then ir_enable+pc_enable -> IR=8125, PC=1, decoded=I_LOAD, rd=1, addr=5.
- LOAD: addr_sel=1 with RAM[5]=16'h1234 -> ram_addr=5. Then c_sel=1 + write_reg_enable -> R1=1234; R0, R2, R3 stay 0.
- ADD with R1=7FFF, R2=0001, IR=A1_06 (rd=0, ra=1, rb=2), operation=00, flags_reg_enable + write -> R0=8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- SUB with R1=0003, R2=0005, IR=A2_06, operation=01 -> R0=FFFE, unsigned_overflow=1, neg=1. Then SUB with equal operands -> zero=1.
- Branch: IR=0x0113, branch+pc_enable -> PC=0x13. PC=31 with pc_enable, branch=0 -> PC=0.
- STORE: IR=8243 with R2=ABCD, addr_sel=1 -> ram_addr=3, data_out=ABCD. Assert rst_n low mid-sequence -> PC, IR, registers and flags clear immediately without a clock.
